// File: rtl/cvxif_issue_ctrl.sv
// Offload controller between the issue stage and a CV-X-IF coprocessor.
// It issues one instruction at a time, tracks accepted instructions in flight and turns results or rejections into writeback pulses.
module cvxif_issue_ctrl #(
   parameter int unsigned NrOutstanding = 4,
   parameter int unsigned IdWidth       = 3,
   parameter int unsigned Xlen          = 32
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 flush_i,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic [31:0]                          req_instr_i,
   input  logic [IdWidth-1:0]                   req_id_i,
   output logic                                 x_issue_valid_o,
   input  logic                                 x_issue_ready_i,
   input  logic                                 x_issue_accept_i,
   output logic [31:0]                          x_issue_instr_o,
   output logic [IdWidth-1:0]                   x_issue_id_o,
   input  logic                                 x_result_valid_i,
   output logic                                 x_result_ready_o,
   input  logic [IdWidth-1:0]                   x_result_id_i,
   input  logic [Xlen-1:0]                      x_result_data_i,
   output logic                                 wb_valid_o,
   output logic [IdWidth-1:0]                   wb_id_o,
   output logic [Xlen-1:0]                      wb_data_o,
   output logic                                 wb_exception_o,
   output logic                                 busy_o,
   output logic [$clog2(NrOutstanding+1)-1:0]   outstanding_o,
   output logic                                 err_o
);

   localparam int unsigned     CntW   = $clog2(NrOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(NrOutstanding);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t               state;
   logic [CntW-1:0]      count;
   logic [CntW-1:0]      count_next;
   logic [31:0]          instr;
   logic [IdWidth-1:0]   id;
   logic                 req_hs;
   logic                 accept_hs;
   logic                 reject_wb;
   logic                 result_hs;
   logic                 result_err;
   logic                 result_wb;
   logic                 inc;
   logic                 dec;

   assign req_ready_o      = rst_ni && (state == IDLE) && (count < MaxCnt) && !flush_i;
   assign req_hs           = req_valid_i && req_ready_o;
   assign accept_hs        = (state == ISSUE) && x_issue_ready_i && x_issue_accept_i;
   // A rejection owns the single writeback slot, so results are held off in that cycle.
   assign reject_wb        = (state == ISSUE) && x_issue_ready_i && !x_issue_accept_i && !flush_i;
   assign x_result_ready_o = !reject_wb;
   assign result_hs        = x_result_valid_i && x_result_ready_o;
   assign result_err       = result_hs && (count == '0);
   assign dec              = result_hs && (count != '0);
   assign result_wb        = dec && (state != DRAIN);
   assign inc              = accept_hs && (count < MaxCnt);

   always_comb begin
      count_next = count;
      if (inc && !dec) begin
         count_next = count + 1'b1;
      end else if (dec && !inc) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= IDLE;
         count          <= '0;
         err_o          <= 1'b0;
         instr          <= '0;
         id             <= '0;
         wb_valid_o     <= 1'b0;
         wb_id_o        <= '0;
         wb_data_o      <= '0;
         wb_exception_o <= 1'b0;
      end else begin
         count      <= count_next;
         wb_valid_o <= reject_wb || result_wb;
         if (result_err) begin
            err_o <= 1'b1;
         end
         if (reject_wb) begin
            wb_id_o        <= id;
            wb_data_o      <= '0;
            wb_exception_o <= 1'b1;
         end else if (result_wb) begin
            wb_id_o        <= x_result_id_i;
            wb_data_o      <= x_result_data_i;
            wb_exception_o <= 1'b0;
         end
         if (req_hs) begin
            instr <= req_instr_i;
            id    <= req_id_i;
         end
         // Flush uses the post-handshake count so an accept in the same cycle is still drained.
         if (flush_i) begin
            state <= (count_next != '0) ? DRAIN : IDLE;
         end else begin
            case (state)
               IDLE:    if (req_hs) state <= ISSUE;
               ISSUE:   if (x_issue_ready_i) state <= IDLE;
               DRAIN:   if (count_next == '0) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign x_issue_valid_o = (state == ISSUE);
   assign x_issue_instr_o = instr;
   assign x_issue_id_o    = id;
   assign busy_o          = (state != IDLE) || (count != '0);
   assign outstanding_o   = count;

endmodule

// File: tb/tb_cvxif_issue_ctrl.sv
// Bench for cvxif_issue_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model of pending issue, in-flight count and drain mode.
module tb_cvxif_issue_ctrl;

   localparam int N  = 4;
   localparam int IW = 3;
   localparam int XL = 32;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_instr = '0;
   logic [IW-1:0] req_id = '0;
   logic          issue_valid;
   logic          issue_ready = 1'b0;
   logic          issue_accept = 1'b0;
   logic [31:0]   issue_instr;
   logic [IW-1:0] issue_id;
   logic          res_valid = 1'b0;
   logic          res_ready;
   logic [IW-1:0] res_id = '0;
   logic [XL-1:0] res_data = '0;
   logic          wb_valid;
   logic [IW-1:0] wb_id;
   logic [XL-1:0] wb_data;
   logic          wb_exc;
   logic          busy;
   logic [CW-1:0] outstanding;
   logic          err;

   cvxif_issue_ctrl #(.NrOutstanding(N), .IdWidth(IW), .Xlen(XL)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_instr_i(req_instr), .req_id_i(req_id),
      .x_issue_valid_o(issue_valid), .x_issue_ready_i(issue_ready), .x_issue_accept_i(issue_accept),
      .x_issue_instr_o(issue_instr), .x_issue_id_o(issue_id),
      .x_result_valid_i(res_valid), .x_result_ready_o(res_ready), .x_result_id_i(res_id),
      .x_result_data_i(res_data),
      .wb_valid_o(wb_valid), .wb_id_o(wb_id), .wb_data_o(wb_data), .wb_exception_o(wb_exc),
      .busy_o(busy), .outstanding_o(outstanding), .err_o(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one pending issue slot, an in-flight counter, a drain flag and the expected writeback.
   int            m_cnt;
   bit            m_pending, m_drain, m_err;
   logic [31:0]   m_instr;
   logic [IW-1:0] m_id;
   bit            m_wbv, m_wbx;
   logic [IW-1:0] m_wbid;
   logic [XL-1:0] m_wbdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_pending = 0; m_drain = 0; m_err = 0;
      m_instr = '0; m_id = '0;
      m_wbv = 0; m_wbx = 0; m_wbid = '0; m_wbdata = '0;
   endtask

   task automatic idle_inputs();
      flush = 0; req_valid = 0; issue_ready = 0; issue_accept = 0; res_valid = 0;
   endtask

   // Check all outputs against the model for the current inputs, then advance one clock.
   task automatic cycle();
      bit rdy, reject, res_hs, acc_hs, req_hs, dec;
      int new_cnt;
      #1;
      rdy    = rst_n && !m_pending && !m_drain && (m_cnt < N) && !flush;
      reject = m_pending && issue_ready && !issue_accept && !flush;
      chk("req_ready", req_ready, rdy);
      chk("issue_valid", issue_valid, m_pending);
      if (m_pending) begin
         chk("issue_instr", issue_instr, m_instr);
         chk("issue_id", issue_id, m_id);
      end
      chk("result_ready", res_ready, !reject);
      chk("wb_valid", wb_valid, m_wbv);
      if (m_wbv) begin
         chk("wb_id", wb_id, m_wbid);
         chk("wb_data", wb_data, m_wbdata);
         chk("wb_exception", wb_exc, m_wbx);
      end
      chk("busy", busy, m_pending || m_drain || (m_cnt != 0));
      chk("outstanding", outstanding, m_cnt);
      chk("err", err, m_err);

      res_hs  = res_valid && !reject;
      acc_hs  = m_pending && issue_ready && issue_accept;
      req_hs  = rdy && req_valid;
      dec     = res_hs && (m_cnt > 0);
      new_cnt = m_cnt + int'(acc_hs) - int'(dec);

      m_wbv = 0;
      if (reject) begin
         m_wbv = 1; m_wbx = 1; m_wbid = m_id; m_wbdata = '0;
      end else if (dec && !m_drain) begin
         m_wbv = 1; m_wbx = 0; m_wbid = res_id; m_wbdata = res_data;
      end
      if (res_hs && m_cnt == 0) m_err = 1;

      if (flush || (m_pending && issue_ready)) begin
         m_pending = 0;
      end else if (req_hs) begin
         m_pending = 1; m_instr = req_instr; m_id = req_id;
      end
      if (flush || m_drain) m_drain = (new_cnt > 0);
      m_cnt = new_cnt;
      if (!rst_n) model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic async_reset(input string tag);
      idle_inputs();
      rst_n = 0;
      #1;
      chk({tag, "_issue_valid"}, issue_valid, 1'b0);
      chk({tag, "_outstanding"}, outstanding, '0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_req_ready"}, req_ready, 1'b0);
      chk({tag, "_wb_valid"}, wb_valid, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
   endtask

   initial begin
      model_reset();
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_issue_valid", issue_valid, 1'b0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_exception", wb_exc, 1'b0);
      chk("rst_wb_id", wb_id, '0);
      chk("rst_wb_data", wb_data, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_outstanding", outstanding, '0);
      chk("rst_err", err, 1'b0);
      rst_n = 1;
      cycle();

      // Basic offload: request, accepted issue, result two cycles later.
      req_valid = 1; req_id = 3'd2; req_instr = 32'h0000_000B; cycle();
      req_valid = 0;
      chk("r29_issue_valid", issue_valid, 1'b1);
      chk("r29_issue_instr", issue_instr, 32'h0000_000B);
      issue_ready = 1; issue_accept = 1; cycle();
      idle_inputs();
      chk("r29_out_one", outstanding, 1);
      cycle();
      res_valid = 1; res_id = 3'd2; res_data = 32'hDEAD_BEEF; cycle();
      idle_inputs();
      chk("r29_wb_valid", wb_valid, 1'b1);
      chk("r29_wb_id", wb_id, 3'd2);
      chk("r29_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("r29_out_zero", outstanding, 0);
      cycle();

      // Rejected issue produces an exception writeback.
      req_valid = 1; req_id = 3'd5; req_instr = 32'h1234_5678; cycle();
      req_valid = 0; issue_ready = 1; issue_accept = 0; cycle();
      idle_inputs();
      chk("r30_wb_valid", wb_valid, 1'b1);
      chk("r30_wb_exception", wb_exc, 1'b1);
      chk("r30_wb_id", wb_id, 3'd5);
      chk("r30_wb_data", wb_data, '0);
      chk("r30_outstanding", outstanding, 0);
      cycle();

      // Fill to the outstanding limit, then free one slot.
      for (int i = 0; i < N; i++) begin
         req_valid = 1; req_id = IW'(i); req_instr = 32'hA000_0000 + 32'(i); cycle();
         req_valid = 0; issue_ready = 1; issue_accept = 1; cycle();
         idle_inputs();
      end
      chk("r31_outstanding_full", outstanding, N);
      chk("r31_req_ready_full", req_ready, 1'b0);
      cycle();
      res_valid = 1; res_id = 3'd0; res_data = 32'h0000_0111; cycle();
      idle_inputs();
      chk("r31_req_ready_freed", req_ready, 1'b1);
      res_valid = 1; res_id = 3'd1; res_data = 32'h0000_0222; cycle();
      idle_inputs();

      // Accept and result in the same cycle with two in flight.
      chk("r32_out_before", outstanding, 2);
      req_valid = 1; req_id = 3'd6; req_instr = 32'hCAFE_0006; cycle();
      req_valid = 0; issue_ready = 1; issue_accept = 1;
      res_valid = 1; res_id = 3'd2; res_data = 32'h0000_0333; cycle();
      idle_inputs();
      chk("r32_outstanding", outstanding, 2);
      chk("r32_wb_valid", wb_valid, 1'b1);
      cycle();
      chk("r32_wb_pulse_end", wb_valid, 1'b0);

      // Flush a stalled issue with three in flight, then drain silently.
      req_valid = 1; req_id = 3'd7; req_instr = 32'hCAFE_0007; cycle();
      req_valid = 0; issue_ready = 1; issue_accept = 1; cycle();
      idle_inputs();
      req_valid = 1; req_id = 3'd4; req_instr = 32'hCAFE_0004; cycle();
      req_valid = 0; cycle();
      chk("r33_stalled", issue_valid, 1'b1);
      flush = 1; cycle();
      idle_inputs();
      chk("r33_issue_dropped", issue_valid, 1'b0);
      chk("r33_out_three", outstanding, 3);
      chk("r33_busy", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         res_valid = 1; res_id = IW'(i); res_data = 32'hBAD0_0000 + 32'(i); cycle();
         idle_inputs();
         chk("r33_no_wb", wb_valid, 1'b0);
      end
      chk("r33_idle", busy, 1'b0);
      chk("r33_req_ready", req_ready, 1'b1);

      // Spurious result with nothing in flight sets a sticky error.
      res_valid = 1; res_id = 3'd3; res_data = 32'h5555_AAAA; cycle();
      idle_inputs();
      chk("r34_err", err, 1'b1);
      chk("r34_no_wb", wb_valid, 1'b0);
      repeat (3) cycle();
      chk("r34_err_sticky", err, 1'b1);
      async_reset("r34_reset");
      cycle();

      // Asynchronous reset while an issue is pending and others are in flight.
      req_valid = 1; req_id = 3'd1; req_instr = 32'h0BAD_0001; cycle();
      req_valid = 0; issue_ready = 1; issue_accept = 1; cycle();
      idle_inputs();
      req_valid = 1; req_id = 3'd2; cycle();
      idle_inputs();
      async_reset("mid_issue");
      repeat (2) cycle();

      // Asynchronous reset in the middle of a drain.
      req_valid = 1; req_id = 3'd3; cycle();
      req_valid = 0; issue_ready = 1; issue_accept = 1; flush = 1; cycle();
      idle_inputs();
      chk("drain_entered", busy, 1'b1);
      async_reset("mid_drain");
      repeat (2) cycle();

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         flush        = ($urandom_range(29) == 0);
         req_valid    = ($urandom_range(1) == 1);
         req_id       = IW'($urandom());
         req_instr    = $urandom();
         issue_ready  = ($urandom_range(1) == 1);
         issue_accept = ($urandom_range(3) != 0);
         res_valid    = (m_cnt > 0) ? ($urandom_range(9) < 3) : ($urandom_range(49) == 0);
         res_id       = IW'($urandom());
         res_data     = $urandom();
         cycle();
         if (i == 400) async_reset("rand_reset");
      end
      idle_inputs();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cvxif_issue_ctrl.md
CVXIF_ISSUE_CTRL -- requirements
Module: cvxif_issue_ctrl

Interface
REQ-001 SHALL have parameter NrOutstanding, default 4, max offloaded instructions in flight at the coprocessor (range 1..8).
REQ-002 SHALL have parameter IdWidth, default 3, width of transaction IDs (2^IdWidth >= NrOutstanding).
REQ-003 SHALL have parameter Xlen, default 32, result data width.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush_i  input  1  pipeline flush, abort pending issue and drain.
REQ-007 SHALL have ports req_valid_i input 1, req_ready_o output 1, req_instr_i input 32, req_id_i input IdWidth: offload request from issue stage.
REQ-008 SHALL have ports x_issue_valid_o output 1, x_issue_ready_i input 1, x_issue_accept_i input 1, x_issue_instr_o output 32, x_issue_id_o output IdWidth: coprocessor issue channel.
REQ-009 SHALL have ports x_result_valid_i input 1, x_result_ready_o output 1, x_result_id_i input IdWidth, x_result_data_i input Xlen: coprocessor result channel.
REQ-010 SHALL have ports wb_valid_o output 1, wb_id_o output IdWidth, wb_data_o output Xlen, wb_exception_o output 1: writeback to scoreboard.
REQ-011 SHALL have ports busy_o output 1 (state != IDLE or count != 0), outstanding_o output $clog2(NrOutstanding+1) (in-flight count), err_o output 1 (sticky protocol error).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-013 req_ready_o SHALL be 1 only when state==IDLE, count<NrOutstanding, flush_i==0.
REQ-014 On req handshake in cycle N, SHALL register instr/id and present x_issue_valid_o=1 from cycle N+1 (state ISSUE); no combinational req->x_issue path.
REQ-015 In ISSUE, x_issue_valid_o, instr, id SHALL stay stable until x_issue_ready_i==1.
REQ-016 Issue handshake with accept=1: count+1, state->IDLE next cycle.
REQ-017 Issue handshake with accept=0: count unchanged, state->IDLE, wb_valid_o=1, wb_exception_o=1, wb_id_o=issued id, wb_data_o=0 in the following cycle.
REQ-018 x_result_ready_o SHALL be 0 in the cycle a rejection writeback is being generated (reject priority), else 1.
REQ-019 Result handshake in cycle M with count>0 and state!=DRAIN: wb_valid_o=1, wb_id_o=x_result_id_i, wb_data_o=x_result_data_i, wb_exception_o=0 in cycle M+1; count-1.
REQ-020 wb_valid_o SHALL be a single-cycle pulse per writeback; no backpressure from writeback.
REQ-021 Accept and result handshakes in the same cycle: count unchanged, both effects applied.
REQ-022 Result handshake with count==0: result dropped, no wb_valid_o, err_o set sticky until reset.
REQ-023 count SHALL never exceed NrOutstanding nor wrap below 0.
REQ-024 flush_i==1 in any state: drop pending ISSUE (x_issue_valid_o=0 next cycle), enter DRAIN if count>0 else IDLE.
REQ-025 In DRAIN: results accepted (ready=1), count decremented, no wb_valid_o; ->IDLE when count reaches 0.
REQ-026 flush_i in the same cycle as an issue handshake with accept=1: that instruction counted, then drained.

Reset
REQ-027 rst_ni low SHALL asynchronously force state IDLE, count 0, err_o 0, req_ready_o 0 while asserted, x_issue_valid_o 0, wb_valid_o 0, wb_exception_o 0, wb_id_o 0, wb_data_o 0, busy_o 0.
REQ-028 Reset mid-ISSUE or mid-DRAIN SHALL discard all in-flight tracking without writeback.

Verification
REQ-029 Req id=2 instr=0x0000_000B, x_issue_ready=1 accept=1, result data=0xDEAD_BEEF two cycles later -> x_issue_valid 1 cycle after req, wb_valid pulse id=2 data=0xDEADBEEF, outstanding 0->1->0.
REQ-030 Issue with accept=0 id=5 -> next cycle wb_valid=1 wb_exception=1 id=5 data=0, outstanding stays 0.
REQ-031 Four accepted issues, no results -> outstanding=4, req_ready_o=0; one result -> req_ready_o=1 following cycle.
REQ-032 Accept and result same cycle with outstanding=2 -> outstanding stays 2, one wb pulse.
REQ-033 flush_i with outstanding=3 during ISSUE stalled (x_issue_ready=0) -> x_issue_valid drops, DRAIN, three results produce no wb_valid, IDLE when outstanding=0.
REQ-034 Result valid with outstanding=0 -> no wb_valid, err_o=1 until rst_ni asserted.
